// File: rtl/complex_pkg.sv
// complex_pkg: shared FSM state type and widths for the round-robin reduction scheduler.
package complex_pkg;
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
    localparam int OPERAND_W = 8;
    localparam int CNT_W = 16;
endpackage

// File: rtl/and_or_tree.sv
// and_or_tree: combinational reduction z = ((p0|p1)&(p2|p3)) | ((p4|p5)&(p6|p7)), p = x & y.
module and_or_tree
    import complex_pkg::*;
(
    input  logic [OPERAND_W-1:0] x,
    input  logic [OPERAND_W-1:0] y,
    output logic                 z
);
    logic [OPERAND_W-1:0] p;
    assign p = x & y;
    assign z = ((p[0] | p[1]) & (p[2] | p[3])) | ((p[4] | p[5]) & (p[6] | p[7]));
endmodule

// File: rtl/complex_arbiter.sv
// complex_arbiter: round-robin scheduler sharing one registered and-or reduction among N_REQ requesters.
module complex_arbiter
    import complex_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [OPERAND_W*N_REQ-1:0] req_x,
    input  logic [OPERAND_W*N_REQ-1:0] req_y,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_z,
    output logic [ID_W-1:0]            rsp_id,
    output logic [CNT_W-1:0]           served_cnt
);
    state_t               state, state_nx;
    logic [ID_W-1:0]      last_grant, grant, op_id;
    logic [OPERAND_W-1:0] op_x, op_y;
    logic                 found, accept, tree_z;
    int                   idx;

    and_or_tree u_tree (.x(op_x), .y(op_y), .z(tree_z));

    // first valid requester scanning upward from the one after last_grant
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    assign accept = rst_n && state == IDLE && found;
    assign req_ready = accept ? N_REQ'(1) << grant : '0;

    always_comb begin
        state_nx = (state == IDLE && found) ? EVAL :
                   (state == EVAL)           ? RESP :
                   (state == RESP && rsp_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            op_x       <= '0;
            op_y       <= '0;
            op_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_id     <= '0;
            served_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_x       <= req_x[int'(grant)*OPERAND_W +: OPERAND_W];
                op_y       <= req_y[int'(grant)*OPERAND_W +: OPERAND_W];
                op_id      <= grant;
                last_grant <= grant;
            end
            if (state == EVAL) begin
                rsp_z     <= tree_z;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid  <= 1'b0;
                served_cnt <= served_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_complex_arbiter.sv
// tb_complex_arbiter: directed and random checks of complex_arbiter against a transaction-level model.
module tb_complex_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_x = '0;
    logic [8*N-1:0] req_y = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_z;
    logic [W-1:0]   rsp_id;
    logic [15:0]    served_cnt;

    int checks = 0;
    int failures = 0;
    bit busy;
    bit m_z;
    int cyc, rsp_at, m_last, m_cnt, m_id;
    logic [15:0] held;

    complex_arbiter #(.N_REQ(N), .ID_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_id(rsp_id), .served_cnt(served_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // result is 1 when either nibble of x&y has both of its bit-pairs nonzero
    function automatic bit ref_z(input logic [7:0] x, input logic [7:0] y);
        int p = int'(x & y);
        for (int h = 0; h < 2; h++)
            if (((p >> (4 * h)) % 4) != 0 && ((p >> (4 * h + 2)) % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic put(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
        req_valid[i] = 1'b1;
    endtask

    task automatic model_reset();
        busy = 1'b0;
        m_last = N - 1;
        m_cnt = 0;
    endtask

    // one clock: check outputs against the model, advance model at the edge
    task automatic cycle();
        int w;
        logic [N-1:0] er;
        bit rv;
        #1;
        w = busy ? -1 : rr_pick(req_valid, m_last);
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        rv = busy && cyc >= rsp_at;
        check("req_ready", 32'(req_ready), 32'(er));
        check("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) begin
            check("rsp_z", 32'(rsp_z), 32'(m_z));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        check("served_cnt", 32'(served_cnt), 32'(m_cnt));
        @(posedge clk);
        if (rv && rsp_ready) begin
            busy = 1'b0;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (w >= 0) begin
            busy = 1'b1;
            rsp_at = cyc + 2;
            m_z = ref_z(req_x[8*w +: 8], req_y[8*w +: 8]);
            m_id = w;
            m_last = w;
        end
        cyc++;
        #1;
        if (w >= 0) req_valid[w] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (busy || req_valid != '0); k++) cycle();
        check("drain_done", 32'(busy || req_valid != '0), 32'(0));
    endtask

    initial begin
        cyc = 0;
        model_reset();
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_z", 32'(rsp_z), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_served_cnt", 32'(served_cnt), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        rst_n = 1'b1;

        put(2, 8'h05, 8'hFF);
        cycle();
        cycle();
        check("single_z", 32'(rsp_z), 32'(1));
        check("single_id", 32'(rsp_id), 32'(2));
        cycle();
        cycle();
        check("single_cnt", 32'(served_cnt), 32'(1));

        put(0, 8'h03, 8'h03);
        repeat (4) cycle();
        check("zero_a", 32'(rsp_z), 32'(0));
        put(1, 8'hF0, 8'h30);
        repeat (4) cycle();
        check("zero_b", 32'(rsp_z), 32'(0));
        put(1, 8'h50, 8'hFF);
        repeat (4) cycle();
        check("one_c", 32'(rsp_z), 32'(1));

        do_reset();
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i]) put(i, 8'($urandom), 8'($urandom));
            repeat (3) cycle();
            check("fair_id", 32'(rsp_id), 32'(t % N));
        end
        check("fair_cnt", 32'(served_cnt), 32'(8));
        drain();

        put(3, 8'hFF, 8'hFF);
        cycle();
        put(0, 8'h0F, 8'h0F);
        cycle();
        rsp_ready = 1'b0;
        held = served_cnt;
        repeat (5) begin
            cycle();
            check("bp_valid", 32'(rsp_valid), 32'(1));
            check("bp_z", 32'(rsp_z), 32'(1));
            check("bp_id", 32'(rsp_id), 32'(3));
            check("bp_ready", 32'(req_ready), 32'(0));
            check("bp_cnt", 32'(served_cnt), 32'(held));
        end
        rsp_ready = 1'b1;
        drain();

        put(1, 8'hFF, 8'hFF);
        cycle();
        put(2, 8'hFF, 8'hFF);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'(0));
        check("mid_rsp_z", 32'(rsp_z), 32'(0));
        check("mid_rsp_id", 32'(rsp_id), 32'(0));
        check("mid_cnt", 32'(served_cnt), 32'(0));
        check("mid_req_ready", 32'(req_ready), 32'(0));
        rst_n = 1'b1;
        req_valid = '0;
        put(0, 8'h11, 8'h33);
        put(3, 8'hFF, 8'hFF);
        #1;
        check("rst_winner", 32'(req_ready), 32'(1));
        drain();

        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(2) == 0) put(i, 8'($urandom), 8'($urandom));
            rsp_ready = $urandom_range(3) != 0;
            cycle();
        end
        rsp_ready = 1'b1;
        drain();

        force dut.served_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        cycle();
        release dut.served_cnt;
        cycle();
        put(0, 8'hFF, 8'hFF);
        repeat (3) cycle();
        check("wrap_cnt", 32'(served_cnt), 32'(0));
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
